// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_pkg
//  Description : Shared Ethernet constants for the GMII receive/transmit path:
//                reflected CRC32 polynomial and residue, preamble/SFD bytes,
//                broadcast MAC, frame-check FSM state encodings and a helper
//                that extracts one byte of a MAC address in wire order.
//  Revision    : 1.0  initial release
// ============================================================================
package eth_pkg;

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  // Register value left after running a correct frame through the CRC,
  // FCS bytes included.
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [47:0] BCAST_MAC     = 48'hFF_FF_FF_FF_FF_FF;

  localparam logic [1:0]  ST_IDLE       = 2'd0;
  localparam logic [1:0]  ST_PREAMBLE   = 2'd1;
  localparam logic [1:0]  ST_DATA       = 2'd2;
  localparam logic [1:0]  ST_DROP       = 2'd3;

  typedef struct packed {
    logic rx_er;
    logic da_miss;
    logic len_err;
    logic crc_err;
  } frame_err_t;

  // Byte idx of a MAC address as it appears on the wire (idx 0 = MSB byte).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [47:0] w_shifted;
    w_shifted = mac << (6'd8 * idx);
    return w_shifted[47:40];
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc32_d8.sv
`default_nettype none
// ============================================================================
//  Module      : crc32_d8
//  Description : Combinational one-byte step of the Ethernet CRC32
//                (reflected polynomial, data consumed LSB first).
//  Ports       : crc_in  [31:0] current CRC register
//                data    [7:0]  byte to absorb
//                crc_out [31:0] CRC register after the byte
//  Revision    : 1.0  initial release
// ============================================================================
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data[i]) begin
        crc_out = (crc_out >> 1) ^ CRC_POLY_REFL;
      end else begin
        crc_out = crc_out >> 1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gmii_rx_frame_check.sv
`default_nettype none
// ============================================================================
//  Module      : gmii_rx_frame_check
//  Description : GMII receive frame qualifier. Strips preamble/SFD, checks
//                CRC32 on the fly, withholds the 4 FCS bytes via a 4-deep
//                delay line, filters destination MAC and frame length and
//                reports a per-frame verdict with good/bad counters.
//  Ports       : gmii_rx_clk            125 MHz receive clock (only clock)
//                sys_rst                synchronous active-high reset
//                gmii_rx_dv/_er/rxd     GMII receive interface
//                out_valid/out_data     frame bytes DA..payload (FCS removed)
//                out_sof                first DA byte marker
//                frame_done             one-cycle end-of-frame pulse
//                frame_good/frame_err   verdict {rx_er,da_miss,len_err,crc_err}
//                good_cnt/bad_cnt       wrapping frame counters
//  Revision    : 1.0  initial release
// ============================================================================
module gmii_rx_frame_check
  import eth_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC   = 48'h00_11_22_33_44_55,
  parameter bit          ALLOW_BCAST = 1'b1,
  parameter int          PRE_MIN     = 1,
  parameter int          MIN_LEN     = 64,
  parameter int          MAX_LEN     = 1518
) (
  input  logic        gmii_rx_clk,
  input  logic        sys_rst,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rxd,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        frame_done,
  output logic        frame_good,
  output logic [3:0]  frame_err,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  localparam logic [3:0]  c_pre_min  = 4'(PRE_MIN);
  localparam logic [10:0] c_min_len  = 11'(MIN_LEN);
  localparam logic [10:0] c_max_len  = 11'(MAX_LEN);
  localparam logic [10:0] c_cnt_max  = 11'h7FF;

  logic [1:0]  r_state;
  logic [3:0]  r_pre_cnt;
  logic [31:0] r_crc;
  logic [10:0] r_byte_cnt;
  logic [7:0]  r_dly [4];
  logic        r_ucast_hit;
  logic        r_bcast_hit;
  logic        r_rx_er;

  logic [31:0] w_crc_next;
  logic        w_data_byte;
  frame_err_t  w_err;

  crc32_d8 u_crc (
    .crc_in  (r_crc),
    .data    (gmii_rxd),
    .crc_out (w_crc_next)
  );

  assign w_data_byte = (r_state == ST_DATA) && gmii_rx_dv;

  // Verdict as it stands when dv drops; only latched on the frame_done cycle.
  always_comb begin
    w_err.rx_er   = r_rx_er;
    w_err.da_miss = (r_byte_cnt < 11'd6) ||
                    !(r_ucast_hit || (ALLOW_BCAST && r_bcast_hit));
    w_err.len_err = (r_byte_cnt < c_min_len) || (r_byte_cnt > c_max_len);
    w_err.crc_err = (r_crc != CRC_RESIDUE);
  end

  // Frame-level FSM, verdict and counters.
  always_ff @(posedge gmii_rx_clk) begin
    if (sys_rst) begin
      r_state    <= ST_IDLE;
      r_pre_cnt  <= 4'd0;
      frame_done <= 1'b0;
      frame_good <= 1'b0;
      frame_err  <= 4'd0;
      good_cnt   <= 16'd0;
      bad_cnt    <= 16'd0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (gmii_rx_dv) begin
            if (gmii_rxd == PREAMBLE_BYTE) begin
              r_state   <= ST_PREAMBLE;
              r_pre_cnt <= 4'd1;
            end else begin
              r_state <= ST_DROP;
            end
          end
        end
        ST_PREAMBLE: begin
          if (!gmii_rx_dv) begin
            r_state <= ST_IDLE;
          end else if (gmii_rxd == PREAMBLE_BYTE) begin
            if (r_pre_cnt != 4'hF) begin
              r_pre_cnt <= r_pre_cnt + 4'd1;
            end
          end else if ((gmii_rxd == SFD_BYTE) && (r_pre_cnt >= c_pre_min)) begin
            r_state <= ST_DATA;
          end else begin
            r_state <= ST_DROP;
          end
        end
        ST_DATA: begin
          if (!gmii_rx_dv) begin
            r_state    <= ST_IDLE;
            frame_done <= 1'b1;
            frame_good <= (w_err == 4'd0);
            frame_err  <= w_err;
            if (w_err == 4'd0) begin
              good_cnt <= good_cnt + 16'd1;
            end else begin
              bad_cnt <= bad_cnt + 16'd1;
            end
          end
        end
        default: begin
          if (!gmii_rx_dv) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Byte datapath: CRC, byte count, DA match, rx_er and FCS hold-back.
  // Everything reinitialises on any cycle that is not a DATA byte, which
  // covers the single-cycle inter-packet gap as well as the SFD cycle.
  always_ff @(posedge gmii_rx_clk) begin
    if (sys_rst) begin
      r_crc       <= CRC_INIT;
      r_byte_cnt  <= 11'd0;
      r_ucast_hit <= 1'b1;
      r_bcast_hit <= 1'b1;
      r_rx_er     <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_dly[k] <= 8'd0;
      end
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      out_data    <= 8'd0;
    end else if (w_data_byte) begin
      r_crc      <= w_crc_next;
      r_byte_cnt <= (r_byte_cnt == c_cnt_max) ? r_byte_cnt : r_byte_cnt + 11'd1;
      if (r_byte_cnt < 11'd6) begin
        r_ucast_hit <= r_ucast_hit && (gmii_rxd == mac_byte(BOARD_MAC, r_byte_cnt[2:0]));
        r_bcast_hit <= r_bcast_hit && (gmii_rxd == mac_byte(BCAST_MAC, r_byte_cnt[2:0]));
      end
      r_rx_er    <= r_rx_er || gmii_rx_er;
      r_dly[0]   <= gmii_rxd;
      r_dly[1]   <= r_dly[0];
      r_dly[2]   <= r_dly[1];
      r_dly[3]   <= r_dly[2];
      // The byte leaving the delay line is four bytes old, so the last four
      // bytes of a frame (the FCS) are still inside it when dv drops.
      out_valid  <= (r_byte_cnt >= 11'd4);
      out_sof    <= (r_byte_cnt == 11'd4);
      out_data   <= r_dly[3];
    end else begin
      r_crc       <= CRC_INIT;
      r_byte_cnt  <= 11'd0;
      r_ucast_hit <= 1'b1;
      r_bcast_hit <= 1'b1;
      r_rx_er     <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_dly[k] <= 8'd0;
      end
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gmii_rx_frame_check.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gmii_rx_frame_check
//  Description : Scoreboard bench for gmii_rx_frame_check. Stimulus pushes
//                expected bytes and verdicts into queues; a monitor pops and
//                compares whenever the DUT presents out_valid or frame_done.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gmii_rx_frame_check;

  localparam logic [47:0] c_board = 48'h00_11_22_33_44_55;
  localparam logic [47:0] c_bcast = 48'hFF_FF_FF_FF_FF_FF;

  logic        gmii_rx_clk = 1'b0;
  logic        sys_rst;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic [7:0]  gmii_rxd;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        frame_done;
  logic        frame_good;
  logic [3:0]  frame_err;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;

  gmii_rx_frame_check dut (
    .gmii_rx_clk (gmii_rx_clk),
    .sys_rst     (sys_rst),
    .gmii_rx_dv  (gmii_rx_dv),
    .gmii_rx_er  (gmii_rx_er),
    .gmii_rxd    (gmii_rxd),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sof     (out_sof),
    .frame_done  (frame_done),
    .frame_good  (frame_good),
    .frame_err   (frame_err),
    .good_cnt    (good_cnt),
    .bad_cnt     (bad_cnt)
  );

  always #4 gmii_rx_clk = ~gmii_rx_clk;

  typedef struct packed { logic sof; logic [7:0] d; } byte_t;
  typedef struct packed { logic good; logic [3:0] err; logic [15:0] g; logic [15:0] b; } verd_t;

  byte_t       exp_b[$];
  verd_t       exp_v[$];
  logic [7:0]  frm[$];
  logic [15:0] exp_good = 16'd0;
  logic [15:0] exp_bad  = 16'd0;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  // Monitor: compare every presented byte / verdict against the queue head.
  always @(negedge gmii_rx_clk) begin
    if (out_valid === 1'b1) begin
      if (exp_b.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_byte actual=%h required=none", out_data);
      end else begin
        byte_t e;
        e = exp_b.pop_front();
        chk("out_byte", {55'd0, out_sof, out_data}, {55'd0, e});
      end
    end
    if (frame_done === 1'b1) begin
      if (exp_v.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_frame_done actual=err%b required=none", frame_err);
      end else begin
        verd_t v;
        v = exp_v.pop_front();
        chk("verdict", {27'd0, frame_good, frame_err, good_cnt, bad_cnt}, {27'd0, v});
      end
    end
  end

  task automatic append_fcs();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (frm[i]) begin
      c = c ^ {24'd0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
  endtask

  // DA, SA 02:00:00:00:00:01, ethertype 0806, payload bytes in 80..BF.
  task automatic build(input logic [47:0] da, input int plen);
    logic [7:0] kb;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(da[47 - 8*i -: 8]);
    frm.push_back(8'h02);
    for (int i = 0; i < 4; i++) frm.push_back(8'h00);
    frm.push_back(8'h01);
    frm.push_back(8'h08);
    frm.push_back(8'h06);
    for (int k = 14; k < plen; k++) begin
      kb = 8'(k);
      frm.push_back(8'h80 | (kb & 8'h3F));
    end
    append_fcs();
  endtask

  task automatic expect_frame(input int nout, input logic [3:0] err);
    byte_t e;
    for (int i = 0; i < nout; i++) begin
      e.sof = (i == 0);
      e.d   = frm[i];
      exp_b.push_back(e);
    end
    if (err == 4'd0) exp_good++;
    else exp_bad++;
    exp_v.push_back({(err == 4'd0), err, exp_good, exp_bad});
  endtask

  task automatic put(input logic [7:0] b, input logic e);
    gmii_rx_dv = 1'b1;
    gmii_rxd   = b;
    gmii_rx_er = e;
    @(negedge gmii_rx_clk);
  endtask

  task automatic idle(input int n);
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    gmii_rx_er = 1'b0;
    repeat (n) @(negedge gmii_rx_clk);
  endtask

  task automatic drive_frame(input int npre, input int er_idx, input int gap);
    for (int i = 0; i < npre; i++) put(8'h55, 1'b0);
    put(8'hD5, 1'b0);
    foreach (frm[i]) put(frm[i], (i == er_idx));
    idle(gap);
  endtask

  initial begin
    repeat (50000) @(posedge gmii_rx_clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sys_rst = 1'b1;
    idle(3);
    sys_rst = 1'b0;
    chk("reset_state", {26'd0, out_valid, out_sof, out_data, frame_done, frame_good,
                        frame_err, good_cnt, bad_cnt}, 64'd0);
    idle(2);

    // 1: broadcast ARP, good
    build(c_bcast, 60); expect_frame(60, 4'b0000); drive_frame(7, -1, 12);
    // 2: payload bit flipped after FCS computed
    build(c_bcast, 60); frm[30] = frm[30] ^ 8'h04; expect_frame(60, 4'b0001); drive_frame(7, -1, 12);
    // 3: unicast DA off by one byte
    build(48'h00_11_22_33_44_66, 60); expect_frame(60, 4'b0100); drive_frame(7, -1, 12);

    // 4: bad preamble -> dropped silently
    build(c_board, 60);
    put(8'h55, 1'b0); put(8'h55, 1'b0); put(8'hAA, 1'b0); put(8'hD5, 1'b0);
    foreach (frm[i]) put(frm[i], 1'b0);
    idle(12);
    chk("drop_counters", {32'd0, good_cnt, bad_cnt}, {32'd0, exp_good, exp_bad});

    // 5: back-to-back with 1-cycle gap
    build(c_board, 60); expect_frame(60, 4'b0000); expect_frame(60, 4'b0000);
    drive_frame(7, -1, 1); drive_frame(7, -1, 12);

    // rx_er mid-frame, minimal preamble
    build(c_board, 80); expect_frame(80, 4'b1000); drive_frame(1, 10, 12);
    // 3-byte frame: too short for DA and length, CRC residue wrong
    frm.delete(); frm.push_back(8'h01); frm.push_back(8'h02); frm.push_back(8'h03);
    expect_frame(0, 4'b0111); drive_frame(7, -1, 12);
    // length boundaries: 63, 1518, 1519 bytes DA..FCS
    build(c_bcast, 59);   expect_frame(59, 4'b0010);   drive_frame(7, -1, 12);
    build(c_board, 1514); expect_frame(1514, 4'b0000); drive_frame(7, -1, 12);
    build(c_board, 1515); expect_frame(1515, 4'b0010); drive_frame(7, -1, 12);

    // 6: reset during DATA byte 20; bytes 0..15 already emitted
    build(c_board, 60);
    for (int i = 0; i < 16; i++) exp_b.push_back({(i == 0), frm[i]});
    for (int i = 0; i < 7; i++) put(8'h55, 1'b0);
    put(8'hD5, 1'b0);
    for (int i = 0; i < 20; i++) put(frm[i], 1'b0);
    sys_rst = 1'b1;
    put(frm[20], 1'b0);
    sys_rst = 1'b0;
    chk("mid_frame_reset", {26'd0, out_valid, out_sof, out_data, frame_done, frame_good,
                            frame_err, good_cnt, bad_cnt}, 64'd0);
    exp_good = 16'd0;
    exp_bad  = 16'd0;
    for (int i = 21; i < 64; i++) put(frm[i], 1'b0);
    idle(12);
    build(c_board, 60); expect_frame(60, 4'b0000); drive_frame(7, -1, 20);

    chk("bytes_drained", 64'(exp_b.size()), 64'd0);
    chk("verdicts_drained", 64'(exp_v.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
